// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial add/subtract controller.
package serial_adder_pkg;

  localparam int unsigned WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bit count for the per-bit step counter; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit combinational full adder cell.
module full_adder (
  output logic s,
  output logic c,
  input  logic a,
  input  logic b,
  input  logic cin
);

  always_comb begin
    s = a ^ b ^ cin;
    c = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller: one full_adder reused over WIDTH cycles,
// operands in on a valid/ready handshake, result out on a valid/ready handshake.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             busy
);

  localparam int unsigned     CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  state_e             state_q;
  logic [CW-1:0]      count_q;
  logic               carry_q;
  logic [WIDTH-1:0]   a_sh_q;
  logic [WIDTH-1:0]   b_sh_q;
  logic [WIDTH-1:0]   res_q;
  logic               cout_q;
  logic               ovf_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               busy_q;

  logic               fa_s;
  logic               fa_c;

  full_adder u_fa (fa_s, fa_c, a_sh_q[0], b_sh_q[0], carry_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      carry_q     <= 1'b0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      res_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            // Subtract as A + ~B + 1: invert B and seed the carry with 1.
            a_sh_q     <= a;
            b_sh_q     <= sub ? ~b : b;
            carry_q    <= sub;
            count_q    <= '0;
            state_q    <= RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          a_sh_q  <= a_sh_q >> 1;
          b_sh_q  <= b_sh_q >> 1;
          res_q   <= {fa_s, res_q[WIDTH-1:1]};
          carry_q <= fa_c;
          count_q <= count_q + 1'b1;
          if (count_q == LAST) begin
            // carry_q here is the carry into the MSB.
            ovf_q       <= carry_q ^ fa_c;
            cout_q      <= fa_c;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sum       = res_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH = 8) against an arithmetic reference model.
module tb_serial_adder_ctrl;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;
  logic         busy;

  int unsigned  cyc = 0;
  int           nchk = 0;
  int           npass = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs === exp) npass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Reference: plain integer arithmetic on the operands' unsigned and signed values.
  task automatic ref_op(input logic [W-1:0] ra, input logic [W-1:0] rb, input logic rs,
                        output logic [W-1:0] es, output logic eco, output logic eov);
    int ua, ub, sa, sb, ur, sr;
    ua = int'(ra);
    ub = int'(rb);
    sa = (ua >= 128) ? ua - 256 : ua;
    sb = (ub >= 128) ? ub - 256 : ub;
    if (rs) begin
      ur  = ua - ub;
      sr  = sa - sb;
      eco = (ua >= ub);
    end else begin
      ur  = ua + ub;
      sr  = sa + sb;
      eco = (ur > 255);
    end
    es  = W'(ur & 255);
    eov = (sr > 127) || (sr < -128);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Called on a negedge in IDLE; returns on the negedge after the result is taken.
  task automatic run_checked(input string tag, input logic [W-1:0] ra, input logic [W-1:0] rb,
                             input logic rs, input logic [W-1:0] es, input logic eco,
                             input logic eov, output int unsigned acc);
    int lat;
    a = ra; b = rb; sub = rs; in_valid = 1'b1;
    @(negedge clk);
    acc = cyc;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; sub = $urandom;
    chk({tag, "_busy_run"}, busy, 1);
    chk({tag, "_inrdy_run"}, in_ready, 0);
    wait_done(lat);
    chk({tag, "_latency"}, lat, 8);
    chk({tag, "_busy_done"}, busy, 1);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, cout, eco);
    chk({tag, "_ovf"}, overflow, eov);
    @(negedge clk);
    chk({tag, "_inrdy_idle"}, in_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] es, sv_sum;
    logic         eco, eov, sv_co, sv_ov;
    int unsigned  acc, prev;
    int           lat;

    repeat (2) @(negedge clk);
    chk("rst_inrdy", in_ready, 1);
    chk("rst_ovalid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", overflow, 0);
    rst_n = 1'b1;
    @(negedge clk);
    out_ready = 1'b1;

    run_checked("add", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, acc);
    run_checked("carry", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, acc);
    run_checked("sovf", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, acc);
    run_checked("sub", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, acc);
    run_checked("subovf", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, acc);

    // Backpressure with new operands pending on the input.
    out_ready = 1'b0;
    ref_op(8'h3C, 8'h55, 1'b0, es, eco, eov);
    a = 8'h3C; b = 8'h55; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_done(lat);
    chk("bp_latency", lat, 8);
    chk("bp_sum", sum, es);
    sv_sum = sum; sv_co = cout; sv_ov = overflow;
    a = 8'h21; b = 8'h11; sub = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_sum", sum, sv_sum);
      chk("bp_hold_cout", cout, sv_co);
      chk("bp_hold_ovf", overflow, sv_ov);
      chk("bp_hold_inrdy", in_ready, 0);
      chk("bp_hold_ovalid", out_valid, 1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_idle_ovalid", out_valid, 0);
    chk("bp_idle_inrdy", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_pend_busy", busy, 1);
    chk("bp_pend_inrdy", in_ready, 0);
    ref_op(8'h21, 8'h11, 1'b1, es, eco, eov);
    wait_done(lat);
    chk("bp_pend_latency", lat, 8);
    chk("bp_pend_sum", sum, es);
    chk("bp_pend_cout", cout, eco);
    chk("bp_pend_ovf", overflow, eov);
    @(negedge clk);

    // Asynchronous reset while count == 3.
    a = 8'hFF; b = 8'hFF; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_ovalid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_sum", sum, 0);
    chk("arst_cout", cout, 0);
    chk("arst_ovf", overflow, 0);
    chk("arst_inrdy", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_checked("post_rst", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, acc);

    // Back-to-back random sweep.
    prev = 0;
    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] ra, rb;
      logic         rs;
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom);
      ref_op(ra, rb, rs, es, eco, eov);
      run_checked("sweep", ra, rb, rs, es, eco, eov, acc);
      if (i > 0) chk("sweep_spacing", acc - prev, 10);
      prev = acc;
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
